add8_err_monitor: RTL and testbench
===================================

Name: add8_err_monitor

Overview:
- Streaming error-characterisation stage placed directly downstream of an 8-bit approximate adder (add8_* family; 8-bit operands, 9-bit sum).
- Consumes operand pairs A/B together with the adder's 9-bit result O, computes the exact sum and accumulates error statistics over a programmed run:
  - SAE (sum of absolute error): gives MAE = SAE / N in software.
  - WCE (worst-case error).
  - EP count (samples with nonzero error).
- Used in hardware sign-off of adder variants against their characterisation figures.

Parameters:
CNT_W, 16, width of sample count and error-count registers
ACC_W, 26, width of SAE accumulator (saturating)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins run, clears statistics
n_samples  input  CNT_W  samples in run, sampled on accepted start
in_valid  input  1  sample present
in_ready  output  1  monitor accepts sample this cycle
in_a  input  8  operand A
in_b  input  8  operand B
in_o  input  9  approximate adder result for (in_a, in_b)
busy  output  1  run in progress
done  output  1  statistics final; held until next accepted start
sae  output  ACC_W  sum of |exact − in_o|, saturating
wce  output  9  maximum |exact − in_o| in run
err_cnt  output  CNT_W  samples with nonzero error
sat  output  1  sticky: SAE saturated during run

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - All outputs 0: in_ready, busy, done, sae, wce, err_cnt, sat.
  - Pipeline valids cleared.
  - Remaining counter 0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start → RUN: latch remaining = n_samples; clear sae/wce/err_cnt/sat/done.
    - If n_samples == 0: go to DONE in the next cycle, with done=1 and zero statistics.
  - RUN:
    - in_ready = 1 while remaining > 0.
    - Transfer occurs when in_valid && in_ready; decrement remaining on each transfer.
    - Transfer with remaining == 1 → DRAIN; in_ready = 0 from the next cycle.
  - DRAIN: wait until both pipeline stages are empty → DONE.
  - DONE: done = 1, busy = 0, statistics stable until next start.
  - start while RUN or DRAIN: ignored (no clear, no reload).
- busy = 1 in RUN and DRAIN.
- Pipeline, 2 stages, no stalls (the monitor never back-pressures in the middle of a run):
  - S1 (registered on transfer):
    - exact = in_a + in_b (9 bits, 0..510).
    - d = exact − in_o, computed at 10-bit signed.
    - e = |d| (9 bits, 0..511).
    - nz = (e != 0).
  - S2 (registered from S1 valid):
    - sae += e, saturating at 2^ACC_W − 1; sat set sticky on the first clamp.
    - wce = max(wce, e).
    - err_cnt += nz. Cannot overflow, because n_samples < 2^CNT_W.
- Latency:
  - A sample transferred in cycle t is reflected in the statistics outputs at t+2.
  - done rises at t+3 after the last transfer at t (DRAIN occupies t+1..t+2).
- in_o is treated as unsigned 9-bit, so in_o > 510 is a legal erroneous value and e is up to 511.
- Gaps: in_valid may drop at any time in RUN. No sample is lost or double-counted.
- Reset mid-run: everything returns to the reset values. A partial run is discarded with no residual statistics.
- Simultaneous start and in_valid in IDLE: only start acts; in_ready is 0 in that cycle.

Decomposition:
- Shared package add8_mon_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - constants OPW=8, SUMW=9, ERRW=10.
- One natural sub-module: add8_err_calc. It is the combinational exact-sum / absolute-difference datapath of S1: 8+8 in, 9-bit result in, 9-bit e and nz out. It is reusable for other add8 monitors.
- FSM, counters and accumulators stay in the top.

Test Plan:
- Exact adder: n_samples=256, in_o=in_a+in_b for random pairs → done=1, sae=0, wce=0, err_cnt=0, sat=0.
- Fixed errors: n_samples=4, pairs (0,0,o=5), (255,255,o=510), (10,20,o=21), (200,100,o=0) → e=5,0,9,300 → sae=314, wce=300, err_cnt=3; done exactly 3 cycles after the 4th transfer.
- Boundary: in_a=0, in_b=0, in_o=511 → wce=511. Then n_samples=0 → done the cycle after start with all statistics 0 and in_ready never asserted.
- Gapped valid plus ignored start: n_samples=8 with in_valid toggling 1010…, plus a start pulse mid-run → exactly 8 transfers, statistics unaffected by the extra start, busy high until DRAIN ends.
- Saturation: ACC_W=10, n_samples=3, each e=511 → sae=1023, sat=1.
- Reset mid-run:
  - Assert rst_n low after 5 of 10 samples → all outputs 0 immediately.
  - A new run of 2 samples (e=1,2) then gives sae=3, wce=2, err_cnt=2.

Source files
------------

// File: rtl/add8_mon_pkg.sv
// Shared types and widths for the add8 error-characterisation monitors.
package add8_mon_pkg;

  localparam int OPW  = 8;   // operand width
  localparam int SUMW = 9;   // exact sum / approximate result width
  localparam int ERRW = 10;  // signed difference width

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // S1 payload: absolute error and its nonzero flag
  typedef struct packed {
    logic [SUMW-1:0] e;
    logic            nz;
  } err_t;

endpackage

// File: rtl/add8_err_calc.sv
// Combinational exact-sum / absolute-error datapath for one add8 sample.
module add8_err_calc
  import add8_mon_pkg::*;
(
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [SUMW-1:0] o,
  output logic [SUMW-1:0] e,
  output logic            nz
);

  logic [SUMW-1:0]        exact;
  logic signed [ERRW-1:0] d;

  assign exact = SUMW'(a) + SUMW'(b);
  // o is unsigned 9-bit, so |d| reaches 511 and still fits SUMW
  assign d     = $signed({1'b0, exact}) - $signed({1'b0, o});
  assign e     = d[ERRW-1] ? SUMW'(-d) : SUMW'(d);
  assign nz    = |e;

endmodule

// File: rtl/add8_err_monitor.sv
// Streaming error-statistics monitor (SAE / WCE / error count) for add8 adders.
module add8_err_monitor
  import add8_mon_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ACC_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  input  logic [SUMW-1:0]  in_o,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sae,
  output logic [SUMW-1:0]  wce,
  output logic [CNT_W-1:0] err_cnt,
  output logic             sat
);

  localparam int STAGES = 1;
  localparam int SW     = ACC_W + 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] remaining;
  logic             start_ok, xfer;
  logic [STAGES:1]  vld_q;
  logic [STAGES:0]  vld_pipe;
  err_t             s1_d, s1_q;
  logic [SW-1:0]    sae_sum;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign in_ready = (state == RUN) && (remaining != '0);
  assign xfer     = in_valid && in_ready;
  assign vld_pipe = {vld_q, xfer};
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  add8_err_calc u_calc (
    .a  (in_a),
    .b  (in_b),
    .o  (in_o),
    .e  (s1_d.e),
    .nz (s1_d.nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A zero-length run skips RUN entirely and reports empty statistics.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (n_samples == '0) ? DONE : RUN;
      RUN:        if (xfer && remaining == CNT_W'(1)) state_nx = DRAIN;
      DRAIN:      if (vld_pipe == '0) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        remaining <= '0;
    else if (start_ok) remaining <= n_samples;
    else if (xfer)     remaining <= remaining - CNT_W'(1);
  end

  // S1: capture per-sample error on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      s1_q  <= '0;
    end else begin
      vld_q[1] <= xfer;
      if (xfer) s1_q <= s1_d;
    end
  end

  // One extra bit of headroom exposes the carry used for clamping.
  assign sae_sum = {1'b0, sae} + SW'(s1_q.e);

  // S2: accumulate statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sae     <= '0;
      wce     <= '0;
      err_cnt <= '0;
      sat     <= 1'b0;
    end else if (start_ok) begin
      sae     <= '0;
      wce     <= '0;
      err_cnt <= '0;
      sat     <= 1'b0;
    end else if (vld_pipe[1]) begin
      if (sae_sum[ACC_W]) begin
        sae <= '1;
        sat <= 1'b1;
      end else begin
        sae <= sae_sum[ACC_W-1:0];
      end
      if (s1_q.e > wce) wce <= s1_q.e;
      err_cnt <= err_cnt + CNT_W'(s1_q.nz);
    end
  end

endmodule

// File: tb/tb_add8_err_monitor.sv
// Directed self-checking bench for add8_err_monitor (default and narrow-SAE instances).
module tb_add8_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] n_samples = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [8:0]  in_o = '0;

  logic        in_ready, busy, done, sat;
  logic [25:0] sae;
  logic [8:0]  wce;
  logic [15:0] err_cnt;

  logic        s_in_ready, s_busy, s_done, s_sat;
  logic [9:0]  s_sae;
  logic [8:0]  s_wce;
  logic [15:0] s_err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add8_err_monitor #(.CNT_W(16), .ACC_W(26)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .done(done), .sae(sae), .wce(wce), .err_cnt(err_cnt), .sat(sat)
  );

  add8_err_monitor #(.CNT_W(16), .ACC_W(10)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(s_busy), .done(s_done), .sae(s_sae), .wce(s_wce), .err_cnt(s_err_cnt), .sat(s_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sample is taken.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
    int k = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_o = o;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 1);
    @(negedge clk);
  endtask

  task automatic start_run(input logic [15:0] n);
    start = 1'b1; n_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (!done && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", 32'(done), 1);
  endtask

  initial begin
    logic [7:0] a, b;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_done",     32'(done), 0);
    chk("rst_sae",      32'(sae), 0);
    chk("rst_wce",      32'(wce), 0);
    chk("rst_err_cnt",  32'(err_cnt), 0);
    chk("rst_sat",      32'(sat), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // exact adder, 256 random pairs
    start_run(16'd256);
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send(a, b, {1'b0, a} + {1'b0, b});
    end
    in_valid = 1'b0;
    wait_done(10);
    chk("exact_sae",     32'(sae), 0);
    chk("exact_wce",     32'(wce), 0);
    chk("exact_err_cnt", 32'(err_cnt), 0);
    chk("exact_sat",     32'(sat), 0);
    chk("exact_busy",    32'(busy), 0);

    // fixed errors 5,0,9,300 with latency checks
    start_run(16'd4);
    send(8'd0,   8'd0,   9'd5);
    send(8'd255, 8'd255, 9'd510);
    send(8'd10,  8'd20,  9'd21);
    send(8'd200, 8'd100, 9'd0);
    in_valid = 1'b0;
    chk("fx_sae_t1",      32'(sae), 14);
    chk("fx_busy_t1",     32'(busy), 1);
    chk("fx_ready_t1",    32'(in_ready), 0);
    @(negedge clk);
    chk("fx_sae",         32'(sae), 314);
    chk("fx_wce",         32'(wce), 300);
    chk("fx_err_cnt",     32'(err_cnt), 3);
    chk("fx_done_t2",     32'(done), 0);
    @(negedge clk);
    chk("fx_done_t3",     32'(done), 1);
    chk("fx_busy_t3",     32'(busy), 0);
    chk("fx_s_sae",       32'(s_sae), 314);

    // boundary: in_o = 511 against exact 0
    start_run(16'd1);
    send(8'd0, 8'd0, 9'd511);
    in_valid = 1'b0;
    wait_done(10);
    chk("bnd_wce", 32'(wce), 511);
    chk("bnd_sae", 32'(sae), 511);

    // zero-length run, with in_valid high alongside start
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1; in_o = 9'd0;
    start = 1'b1; n_samples = 16'd0;
    chk("z_ready_start", 32'(in_ready), 0);
    @(negedge clk);
    start = 1'b0;
    chk("z_done",    32'(done), 1);
    chk("z_sae",     32'(sae), 0);
    chk("z_wce",     32'(wce), 0);
    chk("z_err_cnt", 32'(err_cnt), 0);
    chk("z_busy",    32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      chk("z_ready_hold", 32'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // gapped valid, e = i, plus an ignored start mid-run
    start_run(16'd8);
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_a = 8'(i * 10); in_b = 8'(i); in_o = 9'(i * 12);
      chk("gap_ready", 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0; in_a = 8'd255; in_b = 8'd255; in_o = 9'd0;
      if (i == 4) begin
        start = 1'b1; n_samples = 16'd3;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("gap_busy_t2",  32'(busy), 1);
    chk("gap_done_t2",  32'(done), 0);
    chk("gap_ready_t2", 32'(in_ready), 0);
    chk("gap_sae_t2",   32'(sae), 36);
    @(negedge clk);
    chk("gap_done",     32'(done), 1);
    chk("gap_busy",     32'(busy), 0);
    chk("gap_wce",      32'(wce), 8);
    chk("gap_err_cnt",  32'(err_cnt), 8);

    // saturation on the 10-bit accumulator
    start_run(16'd3);
    repeat (3) send(8'd0, 8'd0, 9'd511);
    in_valid = 1'b0;
    wait_done(10);
    chk("sat_s_sae",  32'(s_sae), 1023);
    chk("sat_s_sat",  32'(s_sat), 1);
    chk("sat_s_wce",  32'(s_wce), 511);
    chk("sat_sae",    32'(sae), 1533);
    chk("sat_nosat",  32'(sat), 0);

    // reset mid-run, then a clean short run
    start_run(16'd10);
    repeat (5) send(8'd10, 8'd10, 9'd17);
    chk("mid_sae", 32'(sae), 12);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_sae",      32'(sae), 0);
    chk("mr_wce",      32'(wce), 0);
    chk("mr_err_cnt",  32'(err_cnt), 0);
    chk("mr_busy",     32'(busy), 0);
    chk("mr_in_ready", 32'(in_ready), 0);
    chk("mr_done",     32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(16'd2);
    send(8'd1, 8'd1, 9'd3);
    send(8'd2, 8'd2, 9'd2);
    in_valid = 1'b0;
    wait_done(10);
    chk("post_sae",     32'(sae), 3);
    chk("post_wce",     32'(wce), 2);
    chk("post_err_cnt", 32'(err_cnt), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
